// File: rtl/fetch_queue.sv
// fetch_queue: IF->ID instruction packet queue with registered-only allowin.
// Define FQ_BYPASS_EN for zero-latency pass-through when the queue is empty.
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int BUS_WD = 81,
  localparam int PTR_WD = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              fs_to_fq_valid,
  input  logic [BUS_WD-1:0] fs_to_fq_bus,
  output logic              fq_allowin,
  input  logic              ds_allowin,
  output logic              fq_to_ds_valid,
  output logic [BUS_WD-1:0] fq_to_ds_bus,
  output logic [PTR_WD:0]   fq_count
);

  localparam logic [PTR_WD:0] FULL = (PTR_WD+1)'(DEPTH);

  logic [BUS_WD-1:0] mem [DEPTH];
  logic [PTR_WD-1:0] wr_ptr;
  logic [PTR_WD-1:0] rd_ptr;
  logic [PTR_WD:0]   count;
  logic              empty;
  logic              push;
  logic              pop;

  assign empty      = (count == '0);
  assign fq_allowin = (count != FULL);
  assign fq_count   = count;

`ifdef FQ_BYPASS_EN
  logic bypass;
  // An empty queue forwards IF's packet directly; it is stored only if ID stalls.
  assign bypass = empty && fs_to_fq_valid && !flush;

  always_comb begin
    fq_to_ds_valid = (!empty || fs_to_fq_valid) && !flush;
    fq_to_ds_bus   = '0;
    if (!empty)
      fq_to_ds_bus = mem[rd_ptr];
    else if (fs_to_fq_valid)
      fq_to_ds_bus = fs_to_fq_bus;
  end

  assign push = fs_to_fq_valid && fq_allowin && !flush
                && !(bypass && ds_allowin);
  assign pop  = !empty && fq_to_ds_valid && ds_allowin;
`else
  always_comb begin
    fq_to_ds_valid = !empty && !flush;
    fq_to_ds_bus   = '0;
    if (!empty)
      fq_to_ds_bus = mem[rd_ptr];
  end

  assign push = fs_to_fq_valid && fq_allowin && !flush;
  assign pop  = fq_to_ds_valid && ds_allowin;
`endif

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= fs_to_fq_bus;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        push && !pop: count <= count + 1'b1;
        pop && !push: count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of ordering, full/empty, wrap, flush, reset.
// Expected packets are rebuilt from the pc by pkt().
module tb_fetch_queue;

  localparam int DEPTH  = 4;
  localparam int BUS_WD = 81;
  localparam int PTR_WD = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              fs_to_fq_valid;
  logic [BUS_WD-1:0] fs_to_fq_bus;
  logic              fq_allowin;
  logic              ds_allowin;
  logic              fq_to_ds_valid;
  logic [BUS_WD-1:0] fq_to_ds_bus;
  logic [PTR_WD:0]   fq_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .BUS_WD(BUS_WD)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .fs_to_fq_valid (fs_to_fq_valid),
    .fs_to_fq_bus   (fs_to_fq_bus),
    .fq_allowin     (fq_allowin),
    .ds_allowin     (ds_allowin),
    .fq_to_ds_valid (fq_to_ds_valid),
    .fq_to_ds_bus   (fq_to_ds_bus),
    .fq_count       (fq_count)
  );

  function automatic logic [BUS_WD-1:0] pkt(input logic [31:0] pc);
    logic [31:0] inst;
    inst = pc ^ 32'hdead_beef;
    return {pc, inst, pc[2], pc[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    fs_to_fq_valid = 1'b0;
    fs_to_fq_bus = '0;
    ds_allowin = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    #1;
    chk("rst_allowin", 128'(fq_allowin), 128'(1));
    chk("rst_valid", 128'(fq_to_ds_valid), 128'(0));
    chk("rst_bus", 128'(fq_to_ds_bus), 128'(0));
    chk("rst_count", 128'(fq_count), 128'(0));

    // fill to full with ID stalled
    for (int i = 0; i < 4; i++) begin
      fs_to_fq_valid = 1'b1;
      fs_to_fq_bus = pkt(32'h1c00_0000 + 32'(4 * i));
      #1;
      chk("fill_allowin", 128'(fq_allowin), 128'(1));
      tick;
    end
    fs_to_fq_bus = pkt(32'h1c00_0010);
    #1;
    chk("full_count", 128'(fq_count), 128'(4));
    chk("full_allowin", 128'(fq_allowin), 128'(0));
    chk("full_valid", 128'(fq_to_ds_valid), 128'(1));
    chk("full_head", 128'(fq_to_ds_bus), 128'(pkt(32'h1c00_0000)));
    tick;
    chk("full_hold", 128'(fq_count), 128'(4));
    ds_allowin = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("drain_valid", 128'(fq_to_ds_valid), 128'(1));
      chk("drain_bus", 128'(fq_to_ds_bus),
          128'(pkt(32'h1c00_0000 + 32'(4 * k))));
      if (k == 1)
        chk("refill_allowin", 128'(fq_allowin), 128'(1));
      tick;
      if (k == 1)
        fs_to_fq_valid = 1'b0;
    end
    chk("drain_count", 128'(fq_count), 128'(0));
    chk("drain_empty", 128'(fq_to_ds_valid), 128'(0));

    // steady push+pop at count 2 across pointer wrap
    ds_allowin = 1'b0;
    fs_to_fq_valid = 1'b1;
    fs_to_fq_bus = pkt(32'h1c00_0100);
    tick;
    fs_to_fq_bus = pkt(32'h1c00_0104);
    tick;
    chk("stream_pre", 128'(fq_count), 128'(2));
    ds_allowin = 1'b1;
    for (int j = 0; j < 10; j++) begin
      fs_to_fq_bus = pkt(32'h1c00_0108 + 32'(4 * j));
      #1;
      chk("stream_bus", 128'(fq_to_ds_bus),
          128'(pkt(32'h1c00_0100 + 32'(4 * j))));
      tick;
      chk("stream_count", 128'(fq_count), 128'(2));
    end
    fs_to_fq_valid = 1'b0;
    for (int j = 0; j < 2; j++) begin
      #1;
      chk("stream_tail", 128'(fq_to_ds_bus),
          128'(pkt(32'h1c00_0128 + 32'(4 * j))));
      tick;
    end
    chk("stream_end", 128'(fq_count), 128'(0));

    // flush at count 3 drops the incoming packet
    ds_allowin = 1'b0;
    fs_to_fq_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fs_to_fq_bus = pkt(32'h1c00_0200 + 32'(4 * i));
      tick;
    end
    chk("fl3_count", 128'(fq_count), 128'(3));
    flush = 1'b1;
    ds_allowin = 1'b1;
    fs_to_fq_bus = pkt(32'h1c00_0020);
    #1;
    chk("fl3_valid", 128'(fq_to_ds_valid), 128'(0));
    tick;
    flush = 1'b0;
    fs_to_fq_valid = 1'b0;
    #1;
    chk("fl3_count_after", 128'(fq_count), 128'(0));
    chk("fl3_valid_after", 128'(fq_to_ds_valid), 128'(0));
    chk("fl3_bus_after", 128'(fq_to_ds_bus), 128'(0));
    tick;
    chk("fl3_no_ghost", 128'(fq_to_ds_valid), 128'(0));

    // flush on a full queue with pop requested
    ds_allowin = 1'b0;
    fs_to_fq_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fs_to_fq_bus = pkt(32'h1c00_0300 + 32'(4 * i));
      tick;
    end
    flush = 1'b1;
    ds_allowin = 1'b1;
    fs_to_fq_bus = pkt(32'h1c00_0310);
    #1;
    chk("flf_allowin", 128'(fq_allowin), 128'(0));
    chk("flf_valid", 128'(fq_to_ds_valid), 128'(0));
    tick;
    flush = 1'b0;
    fs_to_fq_valid = 1'b0;
    ds_allowin = 1'b0;
    #1;
    chk("flf_count", 128'(fq_count), 128'(0));
    chk("flf_allowin_after", 128'(fq_allowin), 128'(1));
    fs_to_fq_valid = 1'b1;
    fs_to_fq_bus = pkt(32'h1c00_0400);
    tick;
    fs_to_fq_bus = pkt(32'h1c00_0404);
    tick;
    fs_to_fq_valid = 1'b0;
    #1;
    chk("post_flush_head", 128'(fq_to_ds_bus), 128'(pkt(32'h1c00_0400)));
    chk("pre_rst_count", 128'(fq_count), 128'(2));
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    chk("mid_rst_count", 128'(fq_count), 128'(0));
    chk("mid_rst_valid", 128'(fq_to_ds_valid), 128'(0));

    // empty queue, packet arrives while ID is ready
    ds_allowin = 1'b1;
    fs_to_fq_valid = 1'b1;
    fs_to_fq_bus = pkt(32'h1c00_0040);
    #1;
`ifdef FQ_BYPASS_EN
    chk("byp_valid", 128'(fq_to_ds_valid), 128'(1));
    chk("byp_bus", 128'(fq_to_ds_bus), 128'(pkt(32'h1c00_0040)));
    tick;
    fs_to_fq_valid = 1'b0;
    #1;
    chk("byp_count", 128'(fq_count), 128'(0));
    chk("byp_consumed", 128'(fq_to_ds_valid), 128'(0));
`else
    chk("lat_valid0", 128'(fq_to_ds_valid), 128'(0));
    chk("lat_bus0", 128'(fq_to_ds_bus), 128'(0));
    tick;
    fs_to_fq_valid = 1'b0;
    #1;
    chk("lat_valid1", 128'(fq_to_ds_valid), 128'(1));
    chk("lat_bus1", 128'(fq_to_ds_bus), 128'(pkt(32'h1c00_0040)));
    chk("lat_count1", 128'(fq_count), 128'(1));
    tick;
    chk("lat_count2", 128'(fq_count), 128'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
